instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a three-state sequencer (IDLE, FETCH, EXEC).
//
// Ports:
//   clk       sole clock, rising-edge active
//   rst       asynchronous active-low reset
//   done      controller finished the current instruction; advance the PC
//   en        controller requests a rewind of the PC to START_ADDR (wins over done)
//   mem_req   instruction memory read request, high for every FETCH cycle
//   mem_addr  instruction memory read address (always the PC)
//   mem_ack   memory read data valid this cycle
//   mem_data  instruction word from memory
//   fncode    instruction register driven to the controller
//   valid     fncode holds a fetched, unexecuted instruction
//   pc        current program counter
//   err       sticky fetch-timeout flag; only reset clears it
module instr_fetch #(
  parameter int unsigned        ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter int unsigned        TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic              en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic [15:0]       fncode,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  // The counter reaches TIMEOUT on the edge where it already holds TIMEOUT-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_fncode;
  logic              r_valid;
  logic [7:0]        r_wait;
  logic              r_err;

  logic [1:0]        w_state_d;
  logic [ADDR_W-1:0] w_pc_d;
  logic [15:0]       w_fncode_d;
  logic              w_valid_d;
  logic [7:0]        w_wait_d;
  logic              w_err_d;

  always_comb begin
    w_state_d  = r_state;
    w_pc_d     = r_pc;
    w_fncode_d = r_fncode;
    w_valid_d  = r_valid;
    w_wait_d   = r_wait;
    w_err_d    = r_err;
    case (r_state)
      S_IDLE: begin
        w_state_d = S_FETCH;
        w_wait_d  = '0;
      end
      S_FETCH: begin
        if (mem_ack) begin
          w_fncode_d = mem_data;
          w_valid_d  = 1'b1;
          w_state_d  = S_EXEC;
          w_wait_d   = '0;
        end else if (r_wait == TIMEOUT_LAST) begin
          // Flag the timeout but keep requesting: the fetch is retried.
          w_err_d  = 1'b1;
          w_wait_d = '0;
        end else begin
          w_wait_d = r_wait + 8'd1;
        end
      end
      S_EXEC: begin
        if (en) begin
          w_pc_d    = START_ADDR;
          w_valid_d = 1'b0;
          w_state_d = S_FETCH;
          w_wait_d  = '0;
        end else if (done) begin
          // Natural wrap modulo 2^ADDR_W; no flag on wrap.
          w_pc_d    = r_pc + ADDR_W'(1);
          w_valid_d = 1'b0;
          w_state_d = S_FETCH;
          w_wait_d  = '0;
        end
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= START_ADDR;
      r_fncode <= 16'h0000;
      r_valid  <= 1'b0;
      r_wait   <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_pc     <= w_pc_d;
      r_fncode <= w_fncode_d;
      r_valid  <= w_valid_d;
      r_wait   <= w_wait_d;
      r_err    <= w_err_d;
    end
  end

  // Decoded from the state register so reset drops the request without a clock.
  assign mem_req  = (r_state == S_FETCH);
  assign mem_addr = r_pc;
  assign fncode   = r_fncode;
  assign valid    = r_valid;
  assign pc       = r_pc;
  assign err      = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch (defaults ADDR_W=8,
// START_ADDR=0, TIMEOUT=15). Memory returns 16'h1234 at address 0 and {8'hC0, addr}
// elsewhere, XORed with data_xor.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        done;
  logic        en;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] fncode;
  logic        valid;
  logic [7:0]  pc;
  logic        err;

  logic        ack_en;
  logic        ack_force;
  logic [15:0] data_xor;
  logic [7:0]  exp_pc;
  int          total;
  int          bad;

  instr_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .en       (en),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .fncode   (fncode),
    .valid    (valid),
    .pc       (pc),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return (a == 8'd0) ? 16'h1234 : {8'hC0, a};
  endfunction

  always_comb begin
    mem_ack  = ack_force | (ack_en & mem_req);
    mem_data = mem_word(mem_addr) ^ data_xor;
  end

  // One instruction: done pulse, then the acked fetch; ends #1 after the EXEC edge.
  task automatic step_instr();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    @(posedge clk); #1;
    exp_pc = exp_pc + 8'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem_req); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
    total++; if (fncode !== 16'h0000) begin bad++; $display("FAIL rst_fncode got=%h exp=0000", fncode); end
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h exp=00", pc); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL first_addr got=%h exp=00", mem_addr); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL first_valid got=%b exp=0", valid); end
    @(posedge clk); #1;
    total++; if (fncode !== 16'h1234) begin bad++; $display("FAIL first_fncode got=%h exp=1234", fncode); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL first_valid1 got=%b exp=1", valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL exec_req got=%b exp=0", mem_req); end
    exp_pc = 8'h00;
  endtask

  task automatic test_sequence();
    for (int i = 1; i <= 3; i++) begin
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 8'(i)) begin
        bad++; $display("FAIL seq_addr%0d got req=%b addr=%h exp req=1 addr=%h", i, mem_req, mem_addr, 8'(i));
      end
      @(posedge clk); #1;
      total++;
      if (valid !== 1'b1 || fncode !== mem_word(8'(i))) begin
        bad++; $display("FAIL seq_fetch%0d got valid=%b fncode=%h exp 1 %h", i, valid, fncode, mem_word(8'(i)));
      end
    end
    exp_pc = 8'd3;
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL seq_pc got=%h exp=03", pc); end
  endtask

  task automatic test_ignore();
    // Ack in EXEC must not reload fncode.
    ack_force = 1'b1; data_xor = 16'hFFFF;
    @(posedge clk); #1;
    ack_force = 1'b0; data_xor = 16'h0000;
    total++; if (fncode !== mem_word(8'd3)) begin bad++; $display("FAIL ign_ack got=%h exp=%h", fncode, mem_word(8'd3)); end
    total++; if (valid !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL ign_state got valid=%b req=%b exp 1 0", valid, mem_req); end
    // done/en while in FETCH must not touch pc.
    ack_en = 1'b0; done = 1'b1;
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    done = 1'b0; en = 1'b0; ack_en = 1'b1;
    total++; if (pc !== 8'd4 || mem_req !== 1'b1) begin bad++; $display("FAIL ign_fetch got pc=%h req=%b exp 04 1", pc, mem_req); end
    @(posedge clk); #1;
    total++; if (fncode !== mem_word(8'd4)) begin bad++; $display("FAIL ign_reload got=%h exp=%h", fncode, mem_word(8'd4)); end
    exp_pc = 8'd4;
  endtask

  task automatic test_wrap();
    while (exp_pc != 8'hFF) step_instr();
    total++; if (pc !== 8'hFF || valid !== 1'b1) begin bad++; $display("FAIL wrap_ff got pc=%h valid=%b exp ff 1", pc, valid); end
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    total++; if (pc !== 8'h00 || mem_addr !== 8'h00) begin bad++; $display("FAIL wrap_pc got pc=%h addr=%h exp 00", pc, mem_addr); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b exp=0", err); end
    @(posedge clk); #1;
    total++; if (fncode !== 16'h1234) begin bad++; $display("FAIL wrap_fetch got=%h exp=1234", fncode); end
    exp_pc = 8'h00;
  endtask

  task automatic test_priority();
    repeat (5) step_instr();
    total++; if (pc !== 8'd5) begin bad++; $display("FAIL prio_pre got=%h exp=05", pc); end
    done = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    done = 1'b0; en = 1'b0;
    total++; if (pc !== 8'h00 || mem_addr !== 8'h00 || mem_req !== 1'b1) begin
      bad++; $display("FAIL prio_rewind got pc=%h addr=%h req=%b exp 00 00 1", pc, mem_addr, mem_req);
    end
    @(posedge clk); #1;
    total++; if (fncode !== 16'h1234 || valid !== 1'b1) begin bad++; $display("FAIL prio_fetch got=%h valid=%b exp 1234 1", fncode, valid); end
    exp_pc = 8'h00;
  endtask

  task automatic test_timeout();
    ack_en = 1'b0; done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", err); end
    @(posedge clk); #1;
    total++; if (err !== 1'b1 || mem_req !== 1'b1) begin bad++; $display("FAIL to_set got err=%b req=%b exp 1 1", err, mem_req); end
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL to_retry got req=%b valid=%b exp 1 0", mem_req, valid); end
    ack_en = 1'b1;
    @(posedge clk); #1;
    total++; if (fncode !== mem_word(8'd1) || valid !== 1'b1) begin bad++; $display("FAIL to_load got=%h valid=%b exp %h 1", fncode, valid, mem_word(8'd1)); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid_fetch();
    step_instr();
    ack_en = 1'b0; done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    total++; if (mem_req !== 1'b1 || pc !== 8'd3) begin bad++; $display("FAIL mid_pre got req=%b pc=%h exp 1 03", mem_req, pc); end
    #2;
    rst = 1'b0; ack_force = 1'b1; data_xor = 16'h5A5A;
    #1;
    total++; if (mem_req !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL mid_async got req=%b valid=%b exp 0 0", mem_req, valid); end
    total++; if (err !== 1'b0 || pc !== 8'h00) begin bad++; $display("FAIL mid_clear got err=%b pc=%h exp 0 00", err, pc); end
    @(posedge clk); #1;
    total++; if (fncode !== 16'h0000) begin bad++; $display("FAIL mid_ackdrop got=%h exp=0000", fncode); end
    ack_force = 1'b0; data_xor = 16'h0000; ack_en = 1'b1;
    rst = 1'b1; done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || pc !== 8'h00) begin
      bad++; $display("FAIL mid_restart got req=%b addr=%h pc=%h exp 1 00 00", mem_req, mem_addr, pc);
    end
    @(posedge clk); #1;
    total++; if (fncode !== 16'h1234 || valid !== 1'b1) begin bad++; $display("FAIL mid_refetch got=%h valid=%b exp 1234 1", fncode, valid); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; done = 1'b0; en = 1'b0;
    ack_en = 1'b1; ack_force = 1'b0; data_xor = 16'h0000; exp_pc = 8'h00;
    #1;
    test_reset();
    test_sequence();
    test_ignore();
    test_wrap();
    test_priority();
    test_timeout();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
